// File: rtl/uart_frame_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_frame_engine
//   Full-duplex UART framing engine with parametrised data width, parity mode
//   and TX stop-bit count. The baud divisor is a runtime input and is latched
//   independently by TX and RX at the start of each frame.
//
// Parameters
//   DIV_W      width of baud_div
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  TX stop bits (1 or 2)
//
// Ports
//   clk, rstn       clock, asynchronous active-low reset
//   baud_div        bit period minus one in clk cycles (values < 3 act as 3)
//   tx_data/valid   word to send, valid/ready handshake with tx_ready
//   tx, tx_busy     registered serial output (idle high), frame in progress
//   rx              asynchronous serial input
//   rx_data/valid   received word, one-cycle completion pulse
//   rx_frame_err    first stop bit sampled low
//   rx_parity_err   parity mismatch (never set when PARITY = 0)
//   rx_break        data, parity and stop all sampled low
//   rx_busy         receiver inside a frame
// -----------------------------------------------------------------------------
module uart_frame_engine #(
  parameter int DIV_W     = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_break,
  output logic                 rx_busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  localparam int                IDX_W     = 4;
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [DIV_W-1:0]  MIN_DIV   = DIV_W'(3);
  localparam logic [DIV_W-1:0]  ONE       = DIV_W'(1);
  localparam bit                HAS_PAR   = (PARITY != 0);

  // Parity bit that completes the word to the configured odd/even count.
  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // Clamp so that a bit period is never shorter than 4 clocks; the RX
  // three-sample vote needs M-1 >= 1 and M+1 <= P-1.
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W:0]   p_full;
  logic [DIV_W-1:0] mid_new;
  assign div_eff = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
  assign p_full  = {1'b0, div_eff} + {{DIV_W{1'b0}}, 1'b1};
  assign mid_new = p_full[DIV_W:1];

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  state_t                 tx_state;
  logic [DIV_W-1:0]       tx_per;
  logic [DIV_W-1:0]       tx_cnt;
  logic [DATA_BITS-1:0]   tx_shreg;
  logic [IDX_W-1:0]       tx_idx;
  logic                   tx_par;

  // NOTE: every register here uses <= so all state updates see the
  // pre-edge values; a blocking = would chain updates within one edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= S_IDLE;
      tx_per   <= '0;
      tx_cnt   <= '0;
      tx_shreg <= '0;
      tx_idx   <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
    end else if (tx_state == S_IDLE) begin
      // tx_ready is high throughout IDLE, so tx_valid alone is the handshake.
      if (tx_valid) begin
        tx_state <= S_START;
        tx_per   <= div_eff;
        tx_cnt   <= '0;
        tx_shreg <= tx_data;
        tx_par   <= par_bit(tx_data);
        tx_idx   <= '0;
        tx       <= 1'b0;
        tx_ready <= 1'b0;
        tx_busy  <= 1'b1;
      end
    end else if (tx_cnt != tx_per) begin
      tx_cnt <= tx_cnt + ONE;
    end else begin
      tx_cnt <= '0;
      case (tx_state)
        S_START: begin
          tx_state <= S_DATA;
          tx       <= tx_shreg[0];
        end
        S_DATA: begin
          if (tx_idx == LAST_BIT) begin
            tx_idx <= '0;
            if (HAS_PAR) begin
              tx_state <= S_PAR;
              tx       <= tx_par;
            end else begin
              tx_state <= S_STOP;
              tx       <= 1'b1;
            end
          end else begin
            tx_idx   <= tx_idx + IDX_ONE;
            tx_shreg <= tx_shreg >> 1;
            tx       <= tx_shreg[1];
          end
        end
        S_PAR: begin
          tx_state <= S_STOP;
          tx       <= 1'b1;
        end
        S_STOP: begin
          if (tx_idx == STOP_LAST) begin
            tx_state <= S_IDLE;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
          end else begin
            tx_idx <= tx_idx + IDX_ONE;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver front end: two-flop synchroniser, then a registered falling-edge
  // detector. rx_prev doubles as the sample fed to the voter; it lines up with
  // rx_fall so the first low sample of the start bit is offset 0.
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev, rx_fall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      rx_fall <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      // rx_prev low (e.g. after a break) blocks detection until the line
      // has been high again.
      rx_fall <= rx_prev & ~rx_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_t                 rx_state;
  logic [DIV_W-1:0]       rx_per;
  logic [DIV_W-1:0]       rx_cnt;
  logic [DIV_W-1:0]       rx_mid;
  logic [DATA_BITS-1:0]   rx_shreg;
  logic [IDX_W-1:0]       rx_idx;
  logic                   vote_a, vote_b, rx_par_s, rx_any_one;
  logic                   at_a, at_b, at_res, bit_end, maj;

  assign at_a    = (rx_cnt == rx_mid - ONE);
  assign at_b    = (rx_cnt == rx_mid);
  assign at_res  = (rx_cnt == rx_mid + ONE);
  assign bit_end = (rx_cnt == rx_per);
  assign maj     = (vote_a & vote_b) | (vote_a & rx_prev) | (vote_b & rx_prev);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state      <= S_IDLE;
      rx_per        <= '0;
      rx_cnt        <= '0;
      rx_mid        <= '0;
      rx_shreg      <= '0;
      rx_idx        <= '0;
      vote_a        <= 1'b0;
      vote_b        <= 1'b0;
      rx_par_s      <= 1'b0;
      rx_any_one    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_break      <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rx_state == S_IDLE) begin
        if (rx_fall) begin
          rx_state   <= S_START;
          rx_busy    <= 1'b1;
          rx_cnt     <= ONE;
          rx_per     <= div_eff;
          rx_mid     <= mid_new;
          rx_idx     <= '0;
          rx_any_one <= 1'b0;
        end
      end else begin
        if (at_a) vote_a <= rx_prev;
        if (at_b) vote_b <= rx_prev;
        rx_cnt <= bit_end ? '0 : rx_cnt + ONE;
        case (rx_state)
          S_START: begin
            if (at_res && maj) begin
              rx_state <= S_IDLE;
              rx_busy  <= 1'b0;
            end else if (bit_end) begin
              rx_state <= S_DATA;
            end
          end
          S_DATA: begin
            if (at_res) begin
              rx_shreg   <= {maj, rx_shreg[DATA_BITS-1:1]};
              rx_any_one <= rx_any_one | maj;
            end
            if (bit_end) begin
              if (rx_idx == LAST_BIT) rx_state <= HAS_PAR ? S_PAR : S_STOP;
              else                    rx_idx   <= rx_idx + IDX_ONE;
            end
          end
          S_PAR: begin
            if (at_res) begin
              rx_par_s   <= maj;
              rx_any_one <= rx_any_one | maj;
            end
            if (bit_end) rx_state <= S_STOP;
          end
          S_STOP: begin
            // Leave at mid stop bit so a back-to-back start edge is caught.
            if (at_res) begin
              rx_state      <= S_IDLE;
              rx_busy       <= 1'b0;
              rx_valid      <= 1'b1;
              rx_data       <= rx_shreg;
              rx_frame_err  <= ~maj;
              rx_parity_err <= HAS_PAR && (rx_par_s != par_bit(rx_shreg));
              rx_break      <= ~rx_any_one & ~maj;
            end
          end
          default: rx_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
